mbssoc_interval_timer: RTL and testbench

- Memory-mapped programmable interval timer on the shared SoC data/address bus, decoded downstream of the bus controller alongside RAM.
- Raises a level interrupt request that feeds one bit of the APIC interrupt vector.
- Gives both cores a periodic or one-shot time base for scheduling and syscall timeouts.

---
 rtl/mbssoc_interval_timer_pkg.sv | 20 ++
 rtl/mbssoc_timer_prescaler.sv | 16 +
 rtl/mbssoc_interval_timer.sv | 98 +++++++++
 tb/tb_mbssoc_interval_timer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mbssoc_interval_timer_pkg.sv
// mbssoc_interval_timer_pkg: register map, bit positions and state type for the interval timer
package mbssoc_interval_timer_pkg;
  localparam int REG_WIN_BYTES = 32;
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_LOAD     = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_PRESCALE = 5'h10;
  localparam logic [2:0] IDX_CTRL     = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_LOAD     = OFF_LOAD[4:2];
  localparam logic [2:0] IDX_COUNT    = OFF_COUNT[4:2];
  localparam logic [2:0] IDX_STATUS   = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_PRESCALE = OFF_PRESCALE[4:2];
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IEN  = 2;
  localparam int STAT_PEND = 0;
  localparam int STAT_OVF  = 1;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_e;
endpackage

// File: rtl/mbssoc_timer_prescaler.sv
// mbssoc_timer_prescaler: counts 0..presc while enabled and flags the wrap cycle as tick
module mbssoc_timer_prescaler #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] presc,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = en & (cnt == presc);
  always_ff @(posedge clk)
    cnt <= (rst_n | clr) ? '0 : en ? (tick ? '0 : cnt + W'(1)) : cnt;
endmodule

// File: rtl/mbssoc_interval_timer.sv
// mbssoc_interval_timer: memory-mapped periodic/one-shot timer with level interrupt
module mbssoc_interval_timer
  import mbssoc_interval_timer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_F000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  re,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  int_req
);
  tmr_state_e state_q, state_d;
  logic sel, rd, wr, ctrl_wr, load_wr, status_wr, presc_wr;
  logic running, start, stop, tick, expire, pend_clr;
  logic auto_q, ien_q, pend_q, ovf_q, pend_d, ovf_d;
  logic [DATA_WIDTH-1:0] load_q, count_q, presc_q, count_d, rdata, ctrl_word, status_word;
  logic [2:0] idx;
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];
  assign sel       = addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
  assign idx       = addr[4:2];
  assign wr        = sel & we;
  assign rd        = sel & re & ~we;
  assign ctrl_wr   = wr & (idx == IDX_CTRL);
  assign load_wr   = wr & (idx == IDX_LOAD);
  assign status_wr = wr & (idx == IDX_STATUS);
  assign presc_wr  = wr & (idx == IDX_PRESCALE);
  assign start     = ctrl_wr & data_in[CTRL_EN] & ~running;
  assign stop      = ctrl_wr & ~data_in[CTRL_EN];
  assign expire    = tick & (count_q == '0);
  assign pend_clr  = status_wr & data_in[STAT_PEND];
  mbssoc_timer_prescaler #(.W(DATA_WIDTH)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (running),
    .clr  (start | stop),
    .presc(presc_q),
    .tick (tick)
  );
  always_ff @(posedge clk)
    state_q <= rst_n ? IDLE : state_d;
  always_comb
    state_d = ctrl_wr ? (data_in[CTRL_EN] ? RUN : IDLE) : (expire & ~auto_q) ? IDLE : state_q;
  always_comb
    running = (state_q == RUN);
  always_comb begin
    count_d = start ? load_q : ~tick ? count_q : (count_q != '0) ? count_q - DATA_WIDTH'(1) :
              auto_q ? load_q : count_q;
    pend_d  = expire | (pend_q & ~pend_clr);
    ovf_d   = (expire & pend_q & ~pend_clr) | (ovf_q & ~(status_wr & data_in[STAT_OVF]));
    ctrl_word = '0;
    ctrl_word[CTRL_EN]   = running;
    ctrl_word[CTRL_AUTO] = auto_q;
    ctrl_word[CTRL_IEN]  = ien_q;
    status_word = '0;
    status_word[STAT_PEND] = pend_q;
    status_word[STAT_OVF]  = ovf_q;
    rdata = (idx == IDX_CTRL)     ? ctrl_word :
            (idx == IDX_LOAD)     ? load_q :
            (idx == IDX_COUNT)    ? count_q :
            (idx == IDX_STATUS)   ? status_word :
            (idx == IDX_PRESCALE) ? presc_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      auto_q   <= 1'b0;
      ien_q    <= 1'b0;
      load_q   <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      int_req  <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        auto_q <= data_in[CTRL_AUTO];
        ien_q  <= data_in[CTRL_IEN];
      end
      if (load_wr) load_q <= data_in;
      if (presc_wr) presc_q <= data_in;
      count_q <= count_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      int_req <= pend_q & ien_q;
      data_oe <= rd;
      if (rd) data_out <= rdata;
    end
  end
endmodule

// File: tb/tb_mbssoc_interval_timer.sv
// tb_mbssoc_interval_timer: randomized self-checking bench against an arithmetic timing model
module tb_mbssoc_interval_timer;
  import mbssoc_interval_timer_pkg::*;
  localparam logic [31:0] BASE = 32'h0000_F000;
  logic clk = 1'b0, rst_n = 1'b1, re = 1'b0, we = 1'b0;
  logic [31:0] addr = BASE, data_in = '0, data_out;
  logic data_oe, int_req;
  int checks = 0, errors = 0;
  mbssoc_interval_timer dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .int_req(int_req)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(logic [4:0] off, logic [31:0] d);
    addr = BASE + 32'(off); data_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic rdchk(string tag, logic [4:0] off, logic [31:0] exp);
    addr = BASE + 32'(off); re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    check({tag, "_oe"}, data_oe, 1);
    check(tag, data_out, exp);
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_irq(int bound, output int c);
    c = 0;
    while (!int_req && c < bound) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic clean();
    wr(OFF_CTRL, 0);
    wr(OFF_STATUS, 3);
  endtask
  function automatic int unsigned period(int unsigned l, int unsigned p);
    return (l + 1) * (p + 1);
  endfunction
  // count after m cycles of running: ticks = m/(p+1), one-shot saturates at 0, auto wraps every l+1 ticks
  function automatic logic [31:0] count_at(int unsigned l, int unsigned p, int unsigned m, bit a);
    int unsigned k = m / (p + 1);
    if (a) return l - (k % (l + 1));
    return (k >= l) ? 0 : l - k;
  endfunction
  initial begin
    int unsigned l, p, t, m, k;
    int c;
    bit a;
    logic [31:0] v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check("rst_irq", int_req, 0);
    check("rst_oe", data_oe, 0);
    for (int i = 0; i < 5; i++) rdchk("rst_reg", 5'(i * 4), 0);
    for (int it = 0; it < 4; it++) begin
      l = it == 0 ? 4 : $urandom_range(1, 6);
      p = it == 0 ? 0 : $urandom_range(0, 3);
      t = period(l, p);
      clean();
      wr(OFF_PRESCALE, p); wr(OFF_LOAD, l); wr(OFF_CTRL, 5);
      wait_irq(2000, c);
      check("oneshot_irq_delay", c, t + 1);
      rdchk("oneshot_status", OFF_STATUS, 1);
      rdchk("oneshot_ctrl", OFF_CTRL, 4);
      rdchk("oneshot_count", OFF_COUNT, 0);
      wr(OFF_CTRL, 0);
      idle(1);
      check("ien_mask_irq", int_req, 0);
      rdchk("ien_mask_pend", OFF_STATUS, 1);
    end
    for (int it = 0; it < 6; it++) begin
      l = $urandom_range(3, 9); p = $urandom_range(0, 3); a = 1'($urandom_range(0, 1));
      m = $urandom_range(0, 3 * period(l, p));
      clean();
      wr(OFF_PRESCALE, p); wr(OFF_LOAD, l); wr(OFF_CTRL, a ? 3 : 1);
      idle(m);
      rdchk("count_sample", OFF_COUNT, count_at(l, p, m, a));
    end
    for (int it = 0; it < 3; it++) begin
      l = it == 0 ? 2 : $urandom_range(1, 5);
      p = it == 0 ? 3 : $urandom_range(0, 3);
      t = period(l, p);
      clean();
      wr(OFF_PRESCALE, p); wr(OFF_LOAD, l); wr(OFF_CTRL, 7);
      wait_irq(2000, c);
      check("auto_irq_delay", c, t + 1);
      idle(t - 2);
      rdchk("auto_status_1", OFF_STATUS, 1);
      rdchk("auto_status_2", OFF_STATUS, 3);
      wr(OFF_CTRL, 6);
      wr(OFF_STATUS, 3);
      rdchk("w1c_status", OFF_STATUS, 0);
      check("w1c_irq", int_req, 0);
    end
    for (int it = 0; it < 3; it++) begin
      l = $urandom_range(1, 5); p = $urandom_range(0, 3); t = period(l, p);
      clean();
      wr(OFF_PRESCALE, p); wr(OFF_LOAD, l); wr(OFF_CTRL, 3);
      idle(2 * t - 1);
      wr(OFF_STATUS, 1);
      rdchk("collide_status", OFF_STATUS, 1);
    end
    for (int it = 0; it < 3; it++) begin
      l = $urandom_range(8, 15); p = $urandom_range(1, 3);
      m = $urandom_range(0, 3 * (p + 1));
      while ((m + 1) % (p + 1) == 0) m++;
      clean();
      wr(OFF_PRESCALE, p); wr(OFF_LOAD, l); wr(OFF_CTRL, 1);
      idle(m);
      wr(OFF_CTRL, 0);
      idle($urandom_range(2, 10));
      rdchk("frozen_count", OFF_COUNT, l - m / (p + 1));
    end
    for (int it = 0; it < 2; it++) begin
      l = 12; p = $urandom_range(0, 2); m = $urandom_range(0, 4); k = $urandom_range(0, 4);
      clean();
      wr(OFF_PRESCALE, p); wr(OFF_LOAD, l); wr(OFF_CTRL, 1);
      idle(m);
      wr(OFF_CTRL, 1);
      idle(k);
      rdchk("no_reload_count", OFF_COUNT, count_at(l, p, m + k + 1, 0));
    end
    clean();
    v = $urandom;
    addr = BASE + 32'(OFF_LOAD); data_in = v; re = 1'b1; we = 1'b1;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    check("rw_no_oe", data_oe, 0);
    rdchk("rw_load", OFF_LOAD, v);
    rdchk("byte_offset_ignored", OFF_LOAD + 5'd3, v);
    addr = BASE + 32'h20; data_in = 32'h7; we = 1'b1;
    @(negedge clk);
    addr = BASE + 32'h24; data_in = ~v;
    @(negedge clk);
    we = 1'b0;
    rdchk("decode_ctrl", OFF_CTRL, 0);
    rdchk("decode_load", OFF_LOAD, v);
    addr = BASE + 32'h20; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    check("decode_no_oe", data_oe, 0);
    wr(5'h14, 32'hFFFF_FFFF);
    rdchk("unmapped_14", 5'h14, 0);
    rdchk("unmapped_1c", 5'h1C, 0);
    wr(OFF_PRESCALE, 0); wr(OFF_LOAD, 100); wr(OFF_CTRL, 5);
    idle(10);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    rdchk("midrst_count", OFF_COUNT, 0);
    rdchk("midrst_load", OFF_LOAD, 0);
    rdchk("midrst_ctrl", OFF_CTRL, 0);
    wait_irq(200, c);
    check("midrst_no_irq", int_req, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
